// File: rtl/app_irq_ctrl_if.sv
// OPB slave-side bus bundle for app_irq_ctrl. Big-endian bit numbering: bit 0 is the MSB.
// Master drives the request fields. Slave returns data and a single-cycle acknowledge.
interface app_irq_ctrl_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/app_irq_ctrl.sv
// Sticky 16-source interrupt status with enable and edge/level mode, plus an OPB register slave.
// Ack arrives one cycle after select and writes land at the end of the ack cycle; there is no backpressure.
module app_irq_ctrl #(
    parameter logic [31:0] C_BASEADDR   = 32'h0001_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0001_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32
) (
    input  logic                 OPB_Clk,
    input  logic                 OPB_Rst,
    app_irq_ctrl_if.slave        opb,
    input  logic [15:0]          user_evt,
    output logic [15:0]          app_irq
);
    typedef enum logic {S_IDLE, S_ACK} state_e;

    localparam logic [2:0] W_STATUS = 3'd0, W_ENABLE = 3'd1, W_PENDING = 3'd2,
                           W_FORCE  = 3'd3, W_MODE   = 3'd4, W_EVCNT   = 3'd5;
    localparam logic WIDTH_OK = (C_OPB_AWIDTH == 32) && (C_OPB_DWIDTH == 32);

    state_e      state_q, state_d;
    logic [2:0]  widx_q, widx_d;
    logic        rnw_q, rnw_d;
    logic [15:0] wdat_q, wdat_d;
    logic [15:0] wmask_q, wmask_d;
    logic [31:0] rdat_q, rdat_d;
    logic [15:0] status_q, status_d;
    logic [15:0] enable_q, enable_d;
    logic [15:0] mode_q, mode_d;
    logic [15:0] evt_q, evt_d;
    logic [15:0] app_irq_q, app_irq_d;
    logic [31:0] evcnt_q, evcnt_d;
    logic        first_q, first_d;

    logic [31:0] addr;
    logic        hit;
    logic [31:0] rd_mux;
    logic        wr_vld;
    logic [15:0] wbits, force_bits, clr_bits, rise, set_bits;
    logic        unused_ok;

    assign addr = opb.OPB_ABus;
    assign hit  = opb.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

    always_comb begin
        rd_mux = '0;
        case (opb.OPB_ABus[27:29])
            W_STATUS:  rd_mux[15:0] = status_q;
            W_ENABLE:  rd_mux[15:0] = enable_q;
            W_PENDING: rd_mux[15:0] = status_q & enable_q;
            W_MODE:    rd_mux[15:0] = mode_q;
            W_EVCNT:   rd_mux       = evcnt_q;
            default:   rd_mux       = '0;
        endcase
    end

    // Request fields are captured on the hit so the write can be applied in the ack cycle.
    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        rnw_d   = rnw_q;
        wdat_d  = wdat_q;
        wmask_d = wmask_q;
        rdat_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    state_d = S_ACK;
                    widx_d  = opb.OPB_ABus[27:29];
                    rnw_d   = opb.OPB_RNW;
                    wdat_d  = opb.OPB_DBus[16:31];
                    wmask_d = {{8{opb.OPB_BE[2]}}, {8{opb.OPB_BE[3]}}};
                    if (opb.OPB_RNW) begin
                        rdat_d = rd_mux;
                    end
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_vld     = (state_q == S_ACK) && !rnw_q;
        wbits      = wdat_q & wmask_q;
        force_bits = (wr_vld && widx_q == W_FORCE)  ? wbits : '0;
        clr_bits   = (wr_vld && widx_q == W_STATUS) ? wbits : '0;
        enable_d   = (wr_vld && widx_q == W_ENABLE) ? ((enable_q & ~wmask_q) | wbits) : enable_q;
        mode_d     = (wr_vld && widx_q == W_MODE)   ? ((mode_q & ~wmask_q) | wbits)   : mode_q;

        // The first cycle out of reset has a stale evt_q, so no edge is reported then.
        rise       = user_evt & ~evt_q & ~{16{first_q}};
        set_bits   = (mode_q & user_evt) | (~mode_q & rise) | force_bits;
        status_d   = set_bits | (status_q & ~clr_bits);

        evcnt_d = evcnt_q;
        if (wr_vld && widx_q == W_EVCNT) begin
            evcnt_d = '0;
        end else if (|(set_bits & ~status_q) && (evcnt_q != 32'hFFFF_FFFF)) begin
            evcnt_d = evcnt_q + 32'd1;
        end

        app_irq_d = status_q & enable_q;
        evt_d     = user_evt;
        first_d   = 1'b0;
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q   <= S_IDLE;
            widx_q    <= '0;
            rnw_q     <= 1'b0;
            wdat_q    <= '0;
            wmask_q   <= '0;
            rdat_q    <= '0;
            status_q  <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            evt_q     <= '0;
            app_irq_q <= '0;
            evcnt_q   <= '0;
            first_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            widx_q    <= widx_d;
            rnw_q     <= rnw_d;
            wdat_q    <= wdat_d;
            wmask_q   <= wmask_d;
            rdat_q    <= rdat_d;
            status_q  <= status_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            evt_q     <= evt_d;
            app_irq_q <= app_irq_d;
            evcnt_q   <= evcnt_d;
            first_q   <= first_d;
        end
    end

    assign opb.Sl_DBus    = rdat_q;
    assign opb.Sl_xferAck = (state_q == S_ACK);
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;
    assign app_irq        = app_irq_q;

    assign unused_ok = ^{opb.OPB_seqAddr, opb.OPB_BE[0:1], opb.OPB_DBus[0:15], WIDTH_OK};
endmodule

// File: tb/tb_app_irq_ctrl.sv
// Directed plus randomized checks of app_irq_ctrl against a history-based reference model.
module tb_app_irq_ctrl;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] HIGH = 32'h0001_00FF;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst;
    logic [15:0] user_evt;
    logic [15:0] app_irq;

    int vectors = 0;
    int miscompares = 0;
    logic        use_evt_at_ack = 1'b0;
    logic [15:0] evt_at_ack = '0;

    app_irq_ctrl_if opb_if ();

    app_irq_ctrl #(.C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32)) dut (
        .OPB_Clk  (OPB_Clk),
        .OPB_Rst  (OPB_Rst),
        .opb      (opb_if),
        .user_evt (user_evt),
        .app_irq  (app_irq)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic rnw, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic exp_ack, input string tag,
                       output logic [31:0] rd);
        @(negedge OPB_Clk);
        opb_if.OPB_ABus   = addr;
        opb_if.OPB_BE     = be;
        opb_if.OPB_DBus   = wd;
        opb_if.OPB_RNW    = rnw;
        opb_if.OPB_select = 1'b1;
        @(negedge OPB_Clk);
        chk({tag, "_ack"}, {31'd0, opb_if.Sl_xferAck}, {31'd0, exp_ack});
        rd = opb_if.Sl_DBus;
        if (!exp_ack) chk({tag, "_dbus_noack"}, opb_if.Sl_DBus, 32'd0);
        if (use_evt_at_ack) user_evt = evt_at_ack;
        opb_if.OPB_select = 1'b0;
        opb_if.OPB_RNW    = 1'b0;
        @(negedge OPB_Clk);
        chk({tag, "_ack_once"}, {31'd0, opb_if.Sl_xferAck}, 32'd0);
        chk({tag, "_dbus_idle"}, opb_if.Sl_DBus, 32'd0);
    endtask

    task automatic rd_chk(input int idx, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        bus(1'b1, BASE + 32'(idx * 4), 32'd0, 4'hF, 1'b1, tag, d);
        chk(tag, d, exp);
    endtask

    task automatic wr(input int idx, input logic [31:0] data, input logic [3:0] be, input string tag);
        logic [31:0] d;
        bus(1'b0, BASE + 32'(idx * 4), data, be, 1'b1, tag, d);
    endtask

    initial begin
        logic [15:0] en, md, st, prev, v, setb;
        logic [31:0] d;
        int cnt;

        OPB_Rst = 1'b1;
        user_evt = '0;
        opb_if.OPB_ABus = '0;
        opb_if.OPB_BE = '0;
        opb_if.OPB_DBus = '0;
        opb_if.OPB_RNW = 1'b0;
        opb_if.OPB_select = 1'b0;
        opb_if.OPB_seqAddr = 1'b0;
        repeat (3) @(negedge OPB_Clk);
        chk("rst_ack", {31'd0, opb_if.Sl_xferAck}, 32'd0);
        chk("rst_dbus", opb_if.Sl_DBus, 32'd0);
        chk("rst_irq", {16'd0, app_irq}, 32'd0);
        chk("rst_err", {29'd0, opb_if.Sl_errAck, opb_if.Sl_retry, opb_if.Sl_toutSup}, 32'd0);
        OPB_Rst = 1'b0;

        for (int i = 0; i < 8; i++) rd_chk(i, 32'd0, "rd_reset_word");

        // Edge event on source 0 with ENABLE = 5.
        wr(1, 32'h0000_0005, 4'hF, "wr_en5");
        @(negedge OPB_Clk) user_evt = 16'h0001;
        @(negedge OPB_Clk) user_evt = 16'h0000;
        chk("irq_lag", {16'd0, app_irq}, 32'd0);
        @(negedge OPB_Clk);
        chk("irq_src0", {16'd0, app_irq}, 32'h0001);
        rd_chk(0, 32'h0001, "status_src0");
        rd_chk(2, 32'h0001, "pending_src0");
        rd_chk(5, 32'd1, "evcnt_1");
        wr(0, 32'h0000_0001, 4'hF, "w1c_src0");
        @(negedge OPB_Clk);
        chk("irq_cleared", {16'd0, app_irq}, 32'd0);
        rd_chk(0, 32'd0, "status_cleared");

        // Rise on source 2 in the same cycle as its W1C: set wins.
        evt_at_ack = 16'h0004;
        use_evt_at_ack = 1'b1;
        wr(0, 32'h0000_0004, 4'hF, "w1c_race");
        use_evt_at_ack = 1'b0;
        user_evt = 16'h0000;
        rd_chk(0, 32'h0004, "status_set_wins");
        chk("irq_src2", {16'd0, app_irq}, 32'h0004);
        rd_chk(5, 32'd2, "evcnt_2");
        wr(0, 32'h0000_0004, 4'hF, "w1c_src2");

        // Level mode on source 3.
        wr(4, 32'h0000_0008, 4'hF, "wr_mode3");
        @(negedge OPB_Clk) user_evt = 16'h0008;
        repeat (2) @(negedge OPB_Clk);
        wr(0, 32'h0000_0008, 4'hF, "w1c_level_hi");
        rd_chk(0, 32'h0008, "status_level_held");
        @(negedge OPB_Clk) user_evt = 16'h0000;
        @(negedge OPB_Clk);
        wr(0, 32'h0000_0008, 4'hF, "w1c_level_lo");
        rd_chk(0, 32'd0, "status_level_clr");
        rd_chk(5, 32'd3, "evcnt_level_once");

        // FORCE with everything disabled, then enable.
        wr(1, 32'd0, 4'hF, "wr_en0");
        wr(3, 32'h0000_8000, 4'hF, "force15");
        rd_chk(0, 32'h8000, "status_forced");
        rd_chk(2, 32'd0, "pending_disabled");
        chk("irq_disabled", {16'd0, app_irq}, 32'd0);
        rd_chk(3, 32'd0, "force_reads0");
        rd_chk(5, 32'd4, "evcnt_force");
        wr(1, 32'h0000_FFFF, 4'hF, "wr_enall");
        @(negedge OPB_Clk);
        chk("irq_forced", {16'd0, app_irq}, 32'h8000);

        // Byte-lane write and reserved words.
        wr(1, 32'd0, 4'hF, "wr_en_zero");
        wr(1, 32'h0000_12FF, 4'b0001, "wr_en_be");
        rd_chk(1, 32'h00FF, "enable_be");
        wr(6, 32'hFFFF_FFFF, 4'hF, "wr_rsvd6");
        rd_chk(6, 32'd0, "rsvd6_reads0");

        // Window boundaries.
        bus(1'b1, HIGH + 32'd4, 32'd0, 4'hF, 1'b0, "rd_above_high", d);
        bus(1'b1, BASE - 32'd4, 32'd0, 4'hF, 1'b0, "rd_below_base", d);
        bus(1'b1, 32'h0001_00FC, 32'd0, 4'hF, 1'b1, "rd_last_word", d);
        chk("rd_last_word_dat", d, 32'd0);

        // Any write to EVCNT clears it, even with no byte lanes.
        wr(5, 32'd0, 4'h0, "clr_evcnt");
        rd_chk(5, 32'd0, "evcnt_cleared");

        // Randomized rounds: model keeps status/count from the per-cycle event history.
        for (int r = 0; r < 4; r++) begin
            en = 16'($urandom);
            md = 16'($urandom);
            wr(1, {16'd0, en}, 4'hF, "rnd_en");
            wr(4, {16'd0, md}, 4'hF, "rnd_mode");
            wr(0, 32'h0000_FFFF, 4'hF, "rnd_clr_st");
            wr(5, 32'd0, 4'hF, "rnd_clr_cnt");
            st = '0;
            prev = '0;
            cnt = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge OPB_Clk);
                v = 16'($urandom);
                user_evt = v;
                setb = (md & v) | (~md & v & ~prev);
                if ((setb & ~st) != 16'd0) cnt++;
                st = st | setb;
                prev = v;
            end
            @(negedge OPB_Clk) user_evt = 16'h0000;
            @(negedge OPB_Clk);
            chk("rnd_irq", {16'd0, app_irq}, {16'd0, st & en});
            rd_chk(0, {16'd0, st}, "rnd_status");
            rd_chk(2, {16'd0, st & en}, "rnd_pending");
            rd_chk(5, 32'(cnt), "rnd_evcnt");
        end

        // Reset during a transfer, with events held high across release.
        wr(1, 32'h0000_FFFF, 4'hF, "pre_rst_en");
        wr(3, 32'h0000_FFFF, 4'hF, "pre_rst_force");
        @(negedge OPB_Clk);
        chk("pre_rst_irq", {16'd0, app_irq}, 32'hFFFF);
        @(negedge OPB_Clk);
        OPB_Rst = 1'b1;
        user_evt = 16'hFFFF;
        opb_if.OPB_ABus = BASE;
        opb_if.OPB_RNW = 1'b1;
        opb_if.OPB_select = 1'b1;
        @(negedge OPB_Clk);
        chk("rst_mid_ack", {31'd0, opb_if.Sl_xferAck}, 32'd0);
        chk("rst_mid_dbus", opb_if.Sl_DBus, 32'd0);
        chk("rst_mid_irq", {16'd0, app_irq}, 32'd0);
        opb_if.OPB_select = 1'b0;
        opb_if.OPB_RNW = 1'b0;
        @(negedge OPB_Clk);
        OPB_Rst = 1'b0;
        rd_chk(0, 32'd0, "post_rst_status");
        rd_chk(1, 32'd0, "post_rst_enable");
        rd_chk(5, 32'd0, "post_rst_evcnt");
        user_evt = 16'h0000;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/app_irq_ctrl.md
Name: app_irq_ctrl

Overview:
- OPB slave interrupt front-end that sits directly upstream of the system block.
- Captures 16 user-design event lines, latches them as sticky status bits with per-source enable and edge/level mode, and drives the level-sensitive app_irq[15:0] bus that the system block aggregates into irq_n.
- Software inspects, forces, clears and counts events over OPB.

Parameters:
- C_BASEADDR, 32'h00010000, first byte address decoded.
- C_HIGHADDR, 32'h000100FF, last byte address decoded.
- C_OPB_AWIDTH, 32, OPB address width; only 32 supported.
- C_OPB_DWIDTH, 32, OPB data width; only 32 supported.

Ports:
- OPB_Clk  in  1  sole clock; all logic rising-edge.
- OPB_Rst  in  1  synchronous, active-high reset.
- OPB_ABus  in  [0:31]  address, bit 0 = MSB.
- OPB_BE  in  [0:3]  byte enables; BE[3] = Sl_DBus[24:31].
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; 0 when not acking.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0.
- user_evt  in  [15:0]  event sources, synchronous to OPB_Clk.
- app_irq  out  [15:0]  pending interrupts to the system block, registered.

Behaviour:
- Register bit i (i = 0..15) maps to Sl_DBus/OPB_DBus[31-i]. The 16-bit registers occupy byte lanes BE[2] (bits 15:8) and BE[3] (bits 7:0). A write updates only those bytes whose BE bit is set. Upper bits read 0.
- Word index = OPB_ABus[27:29]. Register map:
  - 0 STATUS: RW1C.
  - 1 ENABLE: RW.
  - 2 PENDING: RO, = STATUS & ENABLE.
  - 3 FORCE: WO; sets STATUS bits written 1; reads 0.
  - 4 MODE: RW; 1 = level, 0 = rising edge.
  - 5 EVCNT: 32-bit; any write clears it; all 4 BE lanes ignored.
  - 6-7: read 0, writes ignored, still acked.
- Hit = OPB_select & (C_BASEADDR <= ABus <= C_HIGHADDR).
- Bus FSM has two states:
  - IDLE -> ACK when hit is sampled high.
  - ACK -> IDLE unconditionally.
  - Sl_xferAck = 1 only in ACK, giving exactly one ack cycle (cycle N+1 for select in N). No re-ack while the FSM is in ACK, even if select stays high.
- Read data is registered and valid only in the ACK cycle; Sl_DBus = 0 otherwise.
- A write takes effect at the end of the ACK cycle and is visible from N+2.
- Edge detect: evt_d <= user_evt each cycle. rise[i] = user_evt[i] & ~evt_d[i].
- set[i] = MODE[i] ? user_evt[i] : rise[i], OR'd with a FORCE write bit.
- STATUS update, per bit each cycle:
  - If set[i], STATUS[i] becomes 1.
  - Else, if a STATUS write with bit=1, STATUS[i] becomes 0.
  - Else, STATUS[i] holds.
  - Set beats clear in the same cycle. In level mode, a clear is ineffective while the input is high.
- ENABLE gates only app_irq/PENDING; disabled sources still latch STATUS.
- app_irq <= STATUS & ENABLE, registered, so app_irq rises 1 cycle after STATUS.
- EVCNT increments by 1 in any cycle where at least one STATUS bit goes 0->1, whatever the number of bits. It saturates at 32'hFFFFFFFF. A write (clear) and an increment in the same cycle give 0.
- A MODE change takes effect the next cycle; evt_d keeps tracking regardless of mode.
- Reset (synchronous, wins over everything):
  - STATUS, ENABLE, MODE, EVCNT, evt_d all 0.
  - FSM goes to IDLE.
  - Sl_xferAck = 0, Sl_DBus = 0, app_irq = 0.
  - A transfer in flight at reset is dropped without ack; the master times out.
  - If user_evt is high when reset is released, it does not count as a rising edge (evt_d reloads on the first cycle after reset).
- Addresses outside the [C_BASEADDR, C_HIGHADDR] window: no ack, Sl_DBus = 0.

Test Plan:
- Reset, then read all 8 words → all 0; each read acked exactly 1 cycle after select; Sl_xferAck high for 1 cycle only.
- ENABLE = 16'h0005, then pulse user_evt[0] for 1 cycle:
  - STATUS = 16'h0001.
  - app_irq = 16'h0001 one cycle later.
  - EVCNT = 1.
  - Write STATUS = 16'h0001 → app_irq = 0.
- Same-cycle rise on user_evt[2] and W1C of bit 2 → STATUS[2] stays 1.
- MODE[3] = 1 with user_evt[3] held high:
  - W1C of bit 3 is ineffective.
  - Drop the input, then W1C → bit clears.
  - EVCNT increments only once.
- FORCE write of 16'h8000 with ENABLE = 0 → STATUS = 16'h8000, PENDING = 0, app_irq = 0. Then ENABLE = 16'hFFFF → app_irq = 16'h8000.
- Partial BE write to ENABLE (BE = 4'b0001, data 32'h0000_12FF) → ENABLE = 16'h00FF.
- Access to C_HIGHADDR + 4 → no ack.
- Assert OPB_Rst mid-transfer → no ack; all outputs 0 on the next cycle.
